fm_wm_adj_readout: RTL

- Read-side sequencer for the accumulated FM×WM×ADJ result memory.
- After a start pulse, walks the memory rows 0..FEATURE_ROWS-1 by driving read_row.
- Captures each returned row and computes the per-row argmax (node class).
- Streams each row out over a valid/ready handshake, then pulses done. It sits between the result memory and the output/host interface of the GCN pipeline.

---
 rtl/fm_wm_adj_readout.sv | 79 +++++++
 1 files changed

// File: rtl/fm_wm_adj_readout.sv
// fm_wm_adj_readout: walks the FM x WM x ADJ result memory row by row and
// streams each row with its argmax class over a valid/ready handshake.
module fm_wm_adj_readout #(
  parameter int FEATURE_ROWS   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int WEIGHT_WIDTH   = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1,
  parameter int FEATURE_WIDTH  = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [FEATURE_WIDTH-1:0]  read_row,
  input  logic [DOT_PROD_WIDTH-1:0] fm_wm_adj_out [0:WEIGHT_COLS-1],
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DOT_PROD_WIDTH-1:0] out_row [0:WEIGHT_COLS-1],
  output logic [FEATURE_WIDTH-1:0]  out_idx,
  output logic [WEIGHT_WIDTH-1:0]   out_class,
  output logic [DOT_PROD_WIDTH-1:0] out_max,
  output logic                      busy,
  output logic                      done
);
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;
  state_t state, state_nxt;
  logic [FEATURE_WIDTH-1:0] row_cnt;
  logic [WEIGHT_WIDTH-1:0] arg_cls;
  logic [DOT_PROD_WIDTH-1:0] arg_max;
  logic last;
  assign last = row_cnt == FEATURE_WIDTH'(FEATURE_ROWS - 1);
  // row_cnt is held at 0 outside a readout, so it doubles as the address
  assign read_row = row_cnt;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // strict compare keeps the lowest column on ties
  always_comb begin
    arg_cls = '0;
    arg_max = fm_wm_adj_out[0];
    for (int i = 1; i < WEIGHT_COLS; i++)
      if (fm_wm_adj_out[i] > arg_max) begin
        arg_max = fm_wm_adj_out[i];
        arg_cls = WEIGHT_WIDTH'(i);
      end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? FETCH : IDLE;
      FETCH:   state_nxt = PRESENT;
      PRESENT: state_nxt = (out_valid && out_ready) ? (last ? DONE : FETCH) : PRESENT;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      row_cnt   <= '0;
      out_row   <= '{default: '0};
      out_idx   <= '0;
      out_class <= '0;
      out_max   <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FETCH) begin
        out_row   <= fm_wm_adj_out;
        out_idx   <= row_cnt;
        out_class <= arg_cls;
        out_max   <= arg_max;
        out_valid <= 1'b1;
      end
      if (state == PRESENT && out_valid && out_ready) begin
        out_valid <= 1'b0;
        if (!last) row_cnt <= row_cnt + 1'b1;
      end
      if (state == DONE) row_cnt <= '0;
    end
  end
endmodule
